vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_plot_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/vga_plot_arbiter.sv | 134 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared constants and types for the VGA pixel plot arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Visible resolution; coordinates at or beyond these are discarded
  localparam int VGA_H_RES = 640;
  localparam int VGA_V_RES = 480;

  // Field widths of one pixel beat
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 24;
  localparam int DROP_W  = 8;

  // Arbiter mode: free round-robin or held by one burst owner
  typedef enum logic [0:0] {
    IDLE_RR = 1'b0,
    LOCKED  = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_plot_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter_if
// Purpose  : Packed multi-requester pixel bus with per-requester ack.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_plot_arbiter_if
  import vga_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         lock;
  logic [N_REQ*X_W-1:0]     req_x;
  logic [N_REQ*Y_W-1:0]     req_y;
  logic [N_REQ*COLOR_W-1:0] req_color;
  logic [N_REQ-1:0]         ack;

  // Requesters drive pixels and see their own ack strobe
  modport master (
    output req, lock, req_x, req_y, req_color,
    input  ack
  );

  // Arbiter samples pixels and returns the one-hot ack
  modport slave (
    input  req, lock, req_x, req_y, req_color,
    output ack
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant starting the search at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Walk ptr, ptr+1, ... (mod N_REQ) and grant the first active requester
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter
// Purpose  : Round-robin arbiter with burst lock that funnels pixel writes
//            from N_REQ requesters into one registered VGA plot port and
//            discards (and counts) off-screen pixels.
// Revision : 1.0 - initial release
// ============================================================================
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int H_RES = VGA_H_RES,
  parameter int V_RES = VGA_V_RES
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  vga_plot_arbiter_if.slave   bus,
  output logic [X_W-1:0]      VGA_X,
  output logic [Y_W-1:0]      VGA_Y,
  output logic [COLOR_W-1:0]  VGA_COLOR,
  output logic                plot,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One extra bit so the limits can be compared without truncation
  localparam logic [X_W:0] c_h_lim = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] c_v_lim = (Y_W+1)'(V_RES);

  arb_state_t         r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [N_REQ-1:0]   w_owner_oh, w_mask, w_grant, w_ack;
  logic               w_accept, w_lock_sel, w_in_range;
  logic [PTR_W-1:0]   w_idx;
  logic [X_W-1:0]     w_x;
  logic [Y_W-1:0]     w_y;
  logic [COLOR_W-1:0] w_color;

  // While locked, only the burst owner is visible to the arbiter
  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
    w_mask = (r_state == LOCKED) ? (bus.req & w_owner_oh) : bus.req;
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (w_mask),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // Ack is gated by reset so nothing is handed off while the block is held
  assign w_ack    = resetn ? w_grant : '0;
  assign bus.ack  = w_ack;
  assign w_accept = |w_ack;

  // Mux out the accepted beat's index, lock flag and pixel fields
  always_comb begin
    w_idx      = '0;
    w_lock_sel = 1'b0;
    w_x        = '0;
    w_y        = '0;
    w_color    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_ack[i]) begin
        w_idx      = PTR_W'(i);
        w_lock_sel = bus.lock[i];
        w_x        = bus.req_x[i*X_W +: X_W];
        w_y        = bus.req_y[i*Y_W +: Y_W];
        w_color    = bus.req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  assign w_in_range = ({1'b0, w_x} < c_h_lim) && ({1'b0, w_y} < c_v_lim);

  // Arbitration state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE_RR;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Next state: a locked beat captures ownership, an unlocked beat releases it
  // and moves the pointer just past the winner
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (w_accept) begin
      if (w_lock_sel) begin
        w_state_nxt = LOCKED;
        w_owner_nxt = w_idx;
      end else begin
        w_state_nxt = IDLE_RR;
        w_ptr_nxt   = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : (w_idx + PTR_W'(1));
      end
    end
  end

  // Register the accepted pixel for the plot port and count discarded ones
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      plot      <= 1'b0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      drop_cnt  <= '0;
    end else begin
      plot <= w_accept && w_in_range;
      if (w_accept && w_in_range) begin
        VGA_X     <= w_x;
        VGA_Y     <= w_y;
        VGA_COLOR <= w_color;
      end
      if (w_accept && !w_in_range && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plot_arbiter
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            compared against a behavioural arbitration/plot model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_plot_arbiter;

  localparam int N = 4;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic [9:0]  VGA_X;
  logic [8:0]  VGA_Y;
  logic [23:0] VGA_COLOR;
  logic        plot;
  logic [7:0]  drop_cnt;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_plot_arbiter_if #(.N_REQ(N)) bus ();

  vga_plot_arbiter #(.N_REQ(N), .H_RES(640), .V_RES(480)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .bus       (bus),
    .VGA_X     (VGA_X),
    .VGA_Y     (VGA_Y),
    .VGA_COLOR (VGA_COLOR),
    .plot      (plot),
    .drop_cnt  (drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side stimulus
  bit          t_req  [N];
  bit          t_lock [N];
  logic [9:0]  t_x    [N];
  logic [8:0]  t_y    [N];
  logic [23:0] t_c    [N];

  // Reference model state
  int          m_ptr;
  bit          m_locked;
  int          m_owner;
  bit          m_plot;
  logic [9:0]  m_x;
  logic [8:0]  m_y;
  logic [23:0] m_c;
  int          m_drop;
  int          m_gnt;
  logic [31:0] seen_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req[i]               = t_req[i];
      bus.lock[i]              = t_lock[i];
      bus.req_x[i*10 +: 10]    = t_x[i];
      bus.req_y[i*9 +: 9]      = t_y[i];
      bus.req_color[i*24 +: 24] = t_c[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_owner = 0; m_plot = 0;
    m_x = '0; m_y = '0; m_c = '0; m_drop = 0; m_gnt = -1;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c, input bit lk);
    t_req[i]  = 1'b1;
    t_lock[i] = lk;
    t_x[i]    = 10'(x);
    t_y[i]    = 9'(y);
    t_c[i]    = 24'(c);
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      t_req[i] = 1'b0; t_lock[i] = 1'b0;
      t_x[i] = '0; t_y[i] = '0; t_c[i] = '0;
    end
  endtask

  // Who should be granted this cycle, from the rotation/lock rules
  function automatic int model_grant();
    if (m_locked) return t_req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (t_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, advance the model across the edge
  task automatic step();
    int          g;
    logic [31:0] em;
    bit          inr;
    bit          n_plot;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic [23:0] nc;
    int          nd;
    drive();
    @(negedge CLOCK_50);
    g  = model_grant();
    em = (g >= 0) ? (32'd1 << g) : 32'd0;
    check("ack", 32'(bus.ack), em);
    check("plot", 32'(plot), 32'(m_plot));
    check("vga_x", 32'(VGA_X), 32'(m_x));
    check("vga_y", 32'(VGA_Y), 32'(m_y));
    check("vga_color", 32'(VGA_COLOR), 32'(m_c));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    seen_ack = 32'(bus.ack);
    n_plot = 0; nx = m_x; ny = m_y; nc = m_c; nd = m_drop;
    if (g >= 0) begin
      inr = (int'(t_x[g]) < 640) && (int'(t_y[g]) < 480);
      if (inr) begin
        n_plot = 1; nx = t_x[g]; ny = t_y[g]; nc = t_c[g];
      end else if (nd < 255) begin
        nd++;
      end
      if (t_lock[g]) begin
        m_locked = 1; m_owner = g;
      end else begin
        m_locked = 0; m_ptr = (g + 1) % N;
      end
    end
    @(posedge CLOCK_50);
    #1;
    m_plot = n_plot; m_x = nx; m_y = ny; m_c = nc; m_drop = nd;
    m_gnt = g;
  endtask

  // Assert reset away from the clock edge with whatever requests are present
  task automatic do_reset();
    drive();
    resetn = 1'b0;
    model_reset();
    #1;
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_x", 32'(VGA_X), 32'd0);
    check("rst_y", 32'(VGA_Y), 32'd0);
    check("rst_color", 32'(VGA_COLOR), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    resetn = 1'b1;
  endtask

  task automatic rand_pix(input int i);
    if ($urandom_range(0, 7) == 0)
      set_pix(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
              int'($urandom), ($urandom_range(0, 3) == 0));
    else
      set_pix(i, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
              int'($urandom), ($urandom_range(0, 3) == 0));
  endtask

  initial begin
    int exp_x;
    logic [31:0] order35 [4];
    order35[0] = 32'd2; order35[1] = 32'd2; order35[2] = 32'd2; order35[3] = 32'd1;

    idle_all();
    model_reset();
    @(posedge CLOCK_50);
    #1;
    do_reset();

    // Single corner pixel from requester 3
    set_pix(3, 639, 479, 24'hFF0000, 1'b0);
    step();
    check("t37_ack", seen_ack, 32'd8);
    check("t37_plot", 32'(plot), 32'd1);
    check("t37_x", 32'(VGA_X), 32'd639);
    check("t37_y", 32'(VGA_Y), 32'd479);
    check("t37_color", 32'(VGA_COLOR), 32'hFF0000);
    idle_all();
    step();
    check("t37_plot_n2", 32'(plot), 32'd0);

    // All four requesting: strict rotation with one-cycle plot latency
    do_reset();
    for (int i = 0; i < N; i++) set_pix(i, 10 + i, 20 + i, 32'h100 + i, 1'b0);
    for (int k = 0; k < 5; k++) begin
      exp_x = int'(t_x[k % N]);
      step();
      check("t34_ack", seen_ack, 32'd1 << (k % N));
      check("t34_plot", 32'(plot), 32'd1);
      check("t34_x", 32'(VGA_X), 32'(exp_x));
      set_pix(k % N, 100 + k, 200 + k, 32'h200 + k, 1'b0);
    end
    idle_all();
    step();

    // Locked burst from requester 1 while requester 0 waits
    do_reset();
    set_pix(0, 1, 1, 1, 1'b0);
    step();
    check("t35_pre", seen_ack, 32'd1);
    set_pix(0, 2, 2, 2, 1'b0);
    set_pix(1, 5, 5, 5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t35_ack", seen_ack, order35[k]);
      if (k == 0) set_pix(1, 6, 6, 6, 1'b1);
      if (k == 1) set_pix(1, 7, 7, 7, 1'b0);
      if (k == 2) t_req[1] = 1'b0;
    end
    idle_all();
    step();

    // Off-screen pixels are acked, never plotted, and counted with saturation
    do_reset();
    set_pix(2, 640, 0, 24'h123456, 1'b0);
    step();
    check("t36_ack_a", seen_ack, 32'd4);
    set_pix(2, 0, 480, 24'h654321, 1'b0);
    step();
    check("t36_ack_b", seen_ack, 32'd4);
    idle_all();
    step();
    check("t36_plot", 32'(plot), 32'd0);
    check("t36_drop2", 32'(drop_cnt), 32'd2);
    for (int k = 0; k < 298; k++) begin
      if (k % 2 == 0) set_pix(2, 640 + (k % 300), 7, k, 1'b0);
      else            set_pix(2, 3, 480 + (k % 30), k, 1'b0);
      step();
    end
    idle_all();
    step();
    check("t36_drop_sat", 32'(drop_cnt), 32'd255);

    // Reset during a LOCKED(2) burst releases the lock and returns ptr to 0
    do_reset();
    set_pix(0, 11, 11, 11, 1'b0);
    step();
    set_pix(0, 12, 12, 12, 1'b0);
    set_pix(2, 30, 30, 30, 1'b1);
    step();
    check("t38_lock_ack", seen_ack, 32'd4);
    t_req[2] = 1'b0;
    step();
    check("t38_wait", seen_ack, 32'd0);
    set_pix(2, 31, 31, 31, 1'b1);
    do_reset();
    step();
    check("t38_after", seen_ack, 32'd1);
    idle_all();
    step();

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!t_req[i] && ($urandom_range(0, 1) == 1)) rand_pix(i);
      end
      step();
      if (m_gnt >= 0) begin
        if ($urandom_range(0, 1) == 1) rand_pix(m_gnt);
        else t_req[m_gnt] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
